pe_array_grid: RTL
==================

PE_ARRAY_GRID -- requirements
Module: pe_array_grid

Interface
REQ-001 SHALL have parameter ROWS, default 3, PE rows (>=2).
REQ-002 SHALL have parameter COLS, default 3, PE columns (>=2).
REQ-003 SHALL have parameter DATA_W, default 4, ifmap/psum lane width.
REQ-004 SHALL have parameter DELAY_CYCLES, default 10, per-PE pipeline depth (>=1).
REQ-005 SHALL use one clock and a synchronous, active-high reset, with ports named clk and rst.
REQ-006 SHALL have port: clk  in  1  rising-edge clock.
REQ-007 SHALL have port: rst  in  1  synchronous active-high reset.
REQ-008 SHALL have port: in_valid  in  1  qualifies all ifmap_in lanes this cycle.
REQ-009 SHALL have port: ifmap_in  in  (ROWS+COLS-1)*DATA_W  lane i at [i*DATA_W +: DATA_W]; lane c (c<COLS) feeds PE(0,c); lane COLS-1+r (r>=1) feeds PE(r,0).
REQ-010 SHALL have port: acc_en  in  1  1 = accumulate mode, 0 = psum pass-through.
REQ-011 SHALL have port: stall  in  1  global hold of all pipeline registers.
REQ-012 SHALL have port: ifmap_out  out  (ROWS+COLS-1)*DATA_W  lane c = PE(ROWS-1,c) ifmap out; lane COLS+r = PE(r,COLS-1) ifmap out, r<ROWS-1.
REQ-013 SHALL have port: ifmap_out_valid  out  ROWS+COLS-1  per-lane valid for ifmap_out.
REQ-014 SHALL have port: psum_out  out  COLS*DATA_W  lane c = PE(ROWS-1,c) psum out.
REQ-015 SHALL have port: psum_valid  out  COLS  per-column valid for psum_out.
REQ-016 SHALL have port: busy  out  1  any valid bit held in any PE pipeline.

Function
REQ-017 SHALL contain ROWS x COLS PEs; ifmap travels diagonally PE(r,c)->PE(r+1,c+1); psum travels vertically PE(r,c)->PE(r+1,c); row-0 psum input is zero with valid 1.
REQ-018 Each PE SHALL be a DELAY_CYCLES-deep register pipeline carrying {valid, ifmap, psum}; a value sampled at edge k is at the PE output after edge k+DELAY_CYCLES-1, i.e. visible DELAY_CYCLES cycles after presentation.
REQ-019 PE input valid SHALL be (ifmap-source valid AND psum-source valid); edge-lane ifmap source valid is in_valid.
REQ-020 Stage-1 psum SHALL be psum_in + ifmap_in modulo 2^DATA_W when acc_en=1, else psum_in; ifmap is forwarded unchanged; acc_en is sampled at stage-1 entry and travels with the data.
REQ-021 When a PE input valid is 0, stage 1 SHALL load valid=0 and data 0.
REQ-022 While stall=1, every pipeline register SHALL hold its value; inputs are ignored; outputs are unchanged.
REQ-023 Outputs SHALL be driven directly from the final pipeline stage (no combinational path from inputs to outputs).
REQ-024 Latency from ifmap_in lane to the far-end ifmap_out SHALL be (number of PEs traversed) x DELAY_CYCLES non-stalled cycles.
REQ-025 busy SHALL be the OR of all stage valid bits, registered-path only.
REQ-026 Arithmetic SHALL wrap silently; no saturation or overflow flag.

Reset
REQ-027 With rst=1 at a clock edge, all pipeline registers SHALL clear (valid=0, data=0); ifmap_out, ifmap_out_valid, psum_out, psum_valid and busy SHALL be 0 the following cycle.
REQ-028 rst SHALL take priority over stall; in-flight data is discarded on reset mid-operation.

Verification (ROWS=COLS=3, DATA_W=8, DELAY_CYCLES=2)
REQ-029 Reset: rst=1 for 2 cycles -> all outputs 0, busy=0.
REQ-030 Latency: acc_en=0, in_valid=1 for one cycle T with ifmap_in lane0=8'h5A -> ifmap_out lane2=8'h5A with ifmap_out_valid[2]=1 for exactly one cycle at T+6.
REQ-031 Accumulate: acc_en=1, all lanes held at 8'h01, in_valid=1 continuously -> from T+6 psum_out lanes 0..2 = 8'h03, psum_valid=3'b111.
REQ-032 Wrap: as REQ-031 with all lanes 8'h60 -> psum_out lanes = 8'h20.
REQ-033 Stall: REQ-030 stimulus plus stall=1 for cycles T+3..T+6 -> 8'h5A appears at T+10, all outputs frozen during stall.
REQ-034 Reset mid-flight: REQ-031 stimulus, rst=1 at T+3 with in_valid=0 thereafter -> no psum_valid pulse ever asserts, busy=0 from T+4.

Source files
------------

// File: rtl/pe_array_grid.sv
// Systolic grid of ROWS x COLS processing elements. Each PE is a fixed-depth
// register pipeline carrying {valid, ifmap, psum}. Ifmap values move
// diagonally and partial sums move vertically, so each bottom-row psum is the
// wrapping sum of the ifmaps met along its column.
module pe_array_grid #(
  parameter int ROWS         = 3,
  parameter int COLS         = 3,
  parameter int DATA_W       = 4,
  parameter int DELAY_CYCLES = 10
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              in_valid,
  input  logic [(ROWS+COLS-1)*DATA_W-1:0]   ifmap_in,
  input  logic                              acc_en,
  input  logic                              stall,
  output logic [(ROWS+COLS-1)*DATA_W-1:0]   ifmap_out,
  output logic [ROWS+COLS-2:0]              ifmap_out_valid,
  output logic [COLS*DATA_W-1:0]            psum_out,
  output logic [COLS-1:0]                   psum_valid,
  output logic                              busy
);

  localparam int NPE = ROWS * COLS;

  // Modular add: the carry out of the lane is dropped on purpose.
  function automatic logic [DATA_W-1:0] wrap_add(input logic [DATA_W-1:0] a,
                                                 input logic [DATA_W-1:0] b);
    return a + b;
  endfunction

  // Final-stage view of every PE, flattened as index r*COLS+c.
  logic [NPE-1:0]        pe_vld_o;
  logic [NPE-1:0]        pe_busy;
  logic [NPE*DATA_W-1:0] pe_ifmap_o;
  logic [NPE*DATA_W-1:0] pe_psum_o;

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_col
      localparam int IDX = r * COLS + c;

      logic              ifmap_src_vld;
      logic [DATA_W-1:0] ifmap_src;
      logic              psum_src_vld;
      logic [DATA_W-1:0] psum_src;
      logic              in_vld;

      logic              vld_p   [DELAY_CYCLES];
      logic [DATA_W-1:0] ifmap_p [DELAY_CYCLES];
      logic [DATA_W-1:0] psum_p  [DELAY_CYCLES];
      logic              any_vld;

      // Ifmap source: top row and left column come from the edge lanes,
      // interior PEs take the up-left neighbour's output.
      if (r == 0) begin : g_ifm_top
        assign ifmap_src_vld = in_valid;
        assign ifmap_src     = ifmap_in[c*DATA_W +: DATA_W];
      end else if (c == 0) begin : g_ifm_left
        assign ifmap_src_vld = in_valid;
        assign ifmap_src     = ifmap_in[(COLS-1+r)*DATA_W +: DATA_W];
      end else begin : g_ifm_diag
        assign ifmap_src_vld = pe_vld_o[IDX-COLS-1];
        assign ifmap_src     = pe_ifmap_o[(IDX-COLS-1)*DATA_W +: DATA_W];
      end

      // Psum source: the top row starts every column from a valid zero.
      if (r == 0) begin : g_psum_top
        assign psum_src_vld = 1'b1;
        assign psum_src     = '0;
      end else begin : g_psum_up
        assign psum_src_vld = pe_vld_o[IDX-COLS];
        assign psum_src     = pe_psum_o[(IDX-COLS)*DATA_W +: DATA_W];
      end

      assign in_vld = ifmap_src_vld & psum_src_vld;

      // PE pipeline: stage 0 does the optional accumulate, later stages only delay.
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int s = 0; s < DELAY_CYCLES; s++) begin
            vld_p[s]   <= 1'b0;
            ifmap_p[s] <= '0;
            psum_p[s]  <= '0;
          end
        end else if (!stall) begin
          // stage 0: entry, accumulate decided by acc_en sampled here
          if (in_vld) begin
            vld_p[0]   <= 1'b1;
            ifmap_p[0] <= ifmap_src;
            psum_p[0]  <= acc_en ? wrap_add(psum_src, ifmap_src) : psum_src;
          end else begin
            vld_p[0]   <= 1'b0;
            ifmap_p[0] <= '0;
            psum_p[0]  <= '0;
          end
          // stages 1..DELAY_CYCLES-1: pure delay
          for (int s = 1; s < DELAY_CYCLES; s++) begin
            vld_p[s]   <= vld_p[s-1];
            ifmap_p[s] <= ifmap_p[s-1];
            psum_p[s]  <= psum_p[s-1];
          end
        end
      end

      // Occupancy of this PE: any stage holding a valid entry.
      always_comb begin
        any_vld = 1'b0;
        for (int s = 0; s < DELAY_CYCLES; s++) any_vld = any_vld | vld_p[s];
      end

      assign pe_vld_o[IDX]                        = vld_p[DELAY_CYCLES-1];
      assign pe_ifmap_o[IDX*DATA_W +: DATA_W]     = ifmap_p[DELAY_CYCLES-1];
      assign pe_psum_o[IDX*DATA_W +: DATA_W]      = psum_p[DELAY_CYCLES-1];
      assign pe_busy[IDX]                         = any_vld;
    end
  end

  // Bottom row drives psum lanes and the first COLS ifmap lanes.
  for (genvar c = 0; c < COLS; c++) begin : g_out_bottom
    localparam int IDX = (ROWS-1) * COLS + c;
    assign ifmap_out[c*DATA_W +: DATA_W] = pe_ifmap_o[IDX*DATA_W +: DATA_W];
    assign ifmap_out_valid[c]            = pe_vld_o[IDX];
    assign psum_out[c*DATA_W +: DATA_W]  = pe_psum_o[IDX*DATA_W +: DATA_W];
    assign psum_valid[c]                 = pe_vld_o[IDX];
  end

  // Right column (excluding the corner, already on lane COLS-1) drives the rest.
  for (genvar r = 0; r < ROWS-1; r++) begin : g_out_right
    localparam int IDX = r * COLS + (COLS-1);
    assign ifmap_out[(COLS+r)*DATA_W +: DATA_W] = pe_ifmap_o[IDX*DATA_W +: DATA_W];
    assign ifmap_out_valid[COLS+r]              = pe_vld_o[IDX];
  end

  assign busy = |pe_busy;

endmodule
